// File: rtl/apb_pmu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : apb_pmu_pkg                                                      |
// | Brief   : Shared types and register map for the APB reset-sequencing PMU. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package apb_pmu_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } pmu_state_t;

  localparam logic [7:0] CTRL_ADDR   = 8'h00;
  localparam logic [7:0] DELAY_ADDR  = 8'h04;
  localparam logic [7:0] STATUS_ADDR = 8'h08;

  localparam int LOCK_BIT = 31;
  localparam int BUSY_BIT = 16;

  // Field layouts sized for the largest supported domain count (16).
  typedef struct packed {
    logic        lock;
    logic [14:0] rsvd;
    logic [15:0] target;
  } ctrl_reg_t;

  typedef struct packed {
    logic [14:0] rsvd;
    logic        busy;
    logic [15:0] rst_n;
  } status_reg_t;

endpackage
`default_nettype wire

// File: rtl/pmu_rst_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : pmu_rst_seq                                                      |
// | Brief   : Steps reset outputs toward a target one domain at a time.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module pmu_rst_seq
  import apb_pmu_pkg::*;
#(
  parameter int NUM_DOM   = 4,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 pclk,
  input  logic                 presetn,
  input  logic [NUM_DOM-1:0]   target,
  input  logic [CNT_WIDTH-1:0] delay,
  output logic [NUM_DOM-1:0]   rst_n,
  output logic                 busy
);

  pmu_state_t           r_state;
  pmu_state_t           w_state_nxt;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_cnt_nxt;
  logic [NUM_DOM-1:0]   r_rst_n;
  logic [NUM_DOM-1:0]   w_rst_n_nxt;
  logic [NUM_DOM-1:0]   w_assert_req;
  logic [NUM_DOM-1:0]   w_release_req;
  logic [NUM_DOM-1:0]   w_flip;
  logic                 w_mismatch;

  assign w_assert_req  = ~target & r_rst_n;
  assign w_release_req = target & ~r_rst_n;
  assign w_mismatch    = (target != r_rst_n);

  // Assertions take priority (highest index first); releases go lowest index first.
  always_comb begin
    w_flip = '0;
    if (|w_assert_req) begin
      for (int i = 0; i < NUM_DOM; i++) begin
        if (w_assert_req[i]) begin
          w_flip    = '0;
          w_flip[i] = 1'b1;
        end
      end
    end else begin
      for (int i = NUM_DOM - 1; i >= 0; i--) begin
        if (w_release_req[i]) begin
          w_flip    = '0;
          w_flip[i] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_rst_n <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_rst_n <= w_rst_n_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_mismatch && (delay != '0)) w_state_nxt = ST_HOLD;
      ST_HOLD: if (r_cnt == '0) w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_cnt_nxt   = r_cnt;
    w_rst_n_nxt = r_rst_n;
    case (r_state)
      ST_IDLE: begin
        if (w_mismatch) begin
          w_rst_n_nxt = r_rst_n ^ w_flip;
          if (delay != '0) w_cnt_nxt = delay - CNT_WIDTH'(1);
        end
      end
      ST_HOLD: if (r_cnt != '0) w_cnt_nxt = r_cnt - CNT_WIDTH'(1);
      default: w_cnt_nxt = '0;
    endcase
  end

  assign rst_n = r_rst_n;
  assign busy  = (r_state == ST_HOLD) | w_mismatch;

endmodule
`default_nettype wire

// File: rtl/apb_pmu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : apb_pmu_seq                                                      |
// | Brief   : APB register front-end for the sequenced per-domain reset PMU.   |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module apb_pmu_seq
  import apb_pmu_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   NUM_DOM    = 4,
  parameter int                   CNT_WIDTH  = 8,
  parameter logic [NUM_DOM-1:0]   RST_INIT   = '0,
  parameter logic [CNT_WIDTH-1:0] DEF_DELAY  = CNT_WIDTH'(15)
) (
  input  logic                  pclk,
  input  logic                  presetn,
  input  logic                  psel,
  input  logic [ADDR_WIDTH-1:0] paddr,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  penable,
  output logic [DATA_WIDTH-1:0] prdata,
  output logic [NUM_DOM-1:0]    sys_rst_n,
  output logic                  pmu_busy
);

  logic                  w_wr_en;
  logic                  w_rd_en;
  logic [7:0]            w_ofs;
  logic [NUM_DOM-1:0]    r_target;
  logic                  r_lock;
  logic [CNT_WIDTH-1:0]  r_delay;
  logic [DATA_WIDTH-1:0] r_prdata;
  logic [DATA_WIDTH-1:0] w_rdata;
  ctrl_reg_t             w_ctrl;
  status_reg_t           w_status;
  logic                  w_unused;

  assign w_wr_en  = psel & penable & pwrite;
  assign w_rd_en  = psel & ~penable & ~pwrite;
  assign w_ofs    = paddr[7:0];
  assign w_unused = ^{paddr, pwdata};

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_target <= RST_INIT;
      r_lock   <= 1'b0;
      r_delay  <= DEF_DELAY;
    end else if (w_wr_en) begin
      // Once locked, CTRL is frozen until the next presetn.
      if ((w_ofs == CTRL_ADDR) && !r_lock) begin
        r_target <= pwdata[NUM_DOM-1:0];
        if (pwdata[LOCK_BIT]) r_lock <= 1'b1;
      end
      if (w_ofs == DELAY_ADDR) r_delay <= pwdata[CNT_WIDTH-1:0];
    end
  end

  always_comb begin
    w_ctrl                         = '0;
    w_ctrl.lock                    = r_lock;
    w_ctrl.target[NUM_DOM-1:0]     = r_target;
    w_status                       = '0;
    w_status.busy                  = pmu_busy;
    w_status.rst_n[NUM_DOM-1:0]    = sys_rst_n;
    w_rdata                        = '0;
    case (w_ofs)
      CTRL_ADDR:   w_rdata[31:0]          = w_ctrl;
      DELAY_ADDR:  w_rdata[CNT_WIDTH-1:0] = r_delay;
      STATUS_ADDR: w_rdata[31:0]          = w_status;
      default:     w_rdata                = '0;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      r_prdata <= '0;
    end else if (w_rd_en) begin
      r_prdata <= w_rdata;
    end
  end

  assign prdata = r_prdata;

  pmu_rst_seq #(
    .NUM_DOM   (NUM_DOM),
    .CNT_WIDTH (CNT_WIDTH)
  ) u_seq (
    .pclk    (pclk),
    .presetn (presetn),
    .target  (r_target),
    .delay   (r_delay),
    .rst_n   (sys_rst_n),
    .busy    (pmu_busy)
  );

endmodule
`default_nettype wire

// File: tb/tb_apb_pmu_seq.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_apb_pmu_seq                                                   |
// | Brief   : Directed self-checking bench for apb_pmu_seq.                    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_apb_pmu_seq;

  localparam logic [7:0] A_CTRL   = 8'h00;
  localparam logic [7:0] A_DELAY  = 8'h04;
  localparam logic [7:0] A_STATUS = 8'h08;

  logic        pclk = 1'b0;
  logic        presetn, presetn2;
  logic        psel, psel2, pwrite, penable;
  logic [31:0] paddr, pwdata;
  logic [31:0] prdata, prdata2;
  logic [3:0]  sys_rst_n, sys_rst_n2;
  logic        pmu_busy, pmu_busy2;

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cycle    = 0;

  always #5 pclk = ~pclk;
  always @(posedge pclk) cycle <= cycle + 1;

  apb_pmu_seq #(.NUM_DOM(4), .RST_INIT(4'b0000)) dut (
    .pclk(pclk), .presetn(presetn), .psel(psel), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .penable(penable), .prdata(prdata), .sys_rst_n(sys_rst_n),
    .pmu_busy(pmu_busy)
  );

  apb_pmu_seq #(.NUM_DOM(4), .RST_INIT(4'b0101)) dut2 (
    .pclk(pclk), .presetn(presetn2), .psel(psel2), .paddr(paddr), .pwrite(pwrite),
    .pwdata(pwdata), .penable(penable), .prdata(prdata2), .sys_rst_n(sys_rst_n2),
    .pmu_busy(pmu_busy2)
  );

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = {24'h0, a}; pwdata = d;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, output logic [31:0] d);
    @(posedge pclk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = {24'h0, a};
    @(posedge pclk); #1;
    penable = 1'b1;
    d = prdata;
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  // Returns the next sys_rst_n value and the cycle stamp of the edge that changed it.
  task automatic wait_change(input int limit, output logic [3:0] val, output int unsigned stamp);
    logic [3:0] prev;
    int n;
    prev = sys_rst_n;
    n = 0;
    do begin
      @(posedge pclk); #1;
      n++;
    end while (sys_rst_n === prev && n < limit);
    val = sys_rst_n;
    stamp = cycle;
    if (sys_rst_n === prev) begin
      n_fail++;
      $display("FAIL wait_change timeout: sys_rst_n stuck at %b after %0d cycles", prev, limit);
    end
  endtask

  task automatic test_reset();
    logic [31:0] rd;
    n_checks++;
    if (sys_rst_n !== 4'b0000) begin n_fail++; $display("FAIL reset_rst_n: got %b exp 0000", sys_rst_n); end
    n_checks++;
    if (pmu_busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b exp 0", pmu_busy); end
    apb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_status: got %h exp 00000000", rd); end
    apb_read(A_DELAY, rd);
    n_checks++;
    if (rd !== 32'hF) begin n_fail++; $display("FAIL reset_delay: got %h exp 0000000f", rd); end
    apb_read(8'h10, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h exp 00000000", rd); end
    apb_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL reset_ctrl: got %h exp 00000000", rd); end
  endtask

  task automatic test_release();
    logic [3:0]  v;
    logic [3:0]  exp_v [4];
    int unsigned t, tp;
    logic [31:0] rd;
    exp_v = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    apb_write(A_DELAY, 32'd3);
    apb_write(A_CTRL, 32'hF);
    tp = cycle;
    for (int i = 0; i < 4; i++) begin
      wait_change(20, v, t);
      n_checks++;
      if (v !== exp_v[i]) begin n_fail++; $display("FAIL release_step%0d: got %b exp %b", i, v, exp_v[i]); end
      n_checks++;
      if ((t - tp) !== ((i == 0) ? 1 : 4)) begin n_fail++; $display("FAIL release_gap%0d: got %0d exp %0d", i, t - tp, (i == 0) ? 1 : 4); end
      if (i < 3) begin
        n_checks++;
        if (pmu_busy !== 1'b1) begin n_fail++; $display("FAIL release_busy%0d: got %b exp 1", i, pmu_busy); end
      end
      tp = t;
    end
    apb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h0001_000F) begin n_fail++; $display("FAIL status_during: got %h exp 0001000f", rd); end
    repeat (6) begin @(posedge pclk); #1; end
    apb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h0000_000F) begin n_fail++; $display("FAIL status_after: got %h exp 0000000f", rd); end
    n_checks++;
    if (pmu_busy !== 1'b0) begin n_fail++; $display("FAIL release_idle_busy: got %b exp 0", pmu_busy); end
  endtask

  task automatic test_assert_order();
    logic [3:0]  v;
    logic [3:0]  exp_v [4];
    int unsigned t, tp;
    exp_v = '{4'b0111, 4'b0011, 4'b0001, 4'b0000};
    apb_write(A_CTRL, 32'h0);
    tp = cycle;
    for (int i = 0; i < 4; i++) begin
      wait_change(20, v, t);
      n_checks++;
      if (v !== exp_v[i]) begin n_fail++; $display("FAIL assert_step%0d: got %b exp %b", i, v, exp_v[i]); end
      n_checks++;
      if ((t - tp) !== ((i == 0) ? 1 : 4)) begin n_fail++; $display("FAIL assert_gap%0d: got %0d exp %0d", i, t - tp, (i == 0) ? 1 : 4); end
      tp = t;
    end
  endtask

  task automatic test_mixed_retarget();
    logic [3:0]  v;
    logic [3:0]  exp_v [4];
    int unsigned t, tp;
    int          n;
    exp_v = '{4'b0001, 4'b0000, 4'b0001, 4'b0011};
    apb_write(A_CTRL, 32'h3);
    repeat (2) wait_change(20, v, t);
    n_checks++;
    if (v !== 4'b0011) begin n_fail++; $display("FAIL mixed_setup: got %b exp 0011", v); end
    n = 0;
    while (pmu_busy === 1'b1 && n < 20) begin @(posedge pclk); #1; n++; end
    apb_write(A_CTRL, 32'hC);
    tp = cycle;
    for (int i = 0; i < 4; i++) begin
      wait_change(20, v, t);
      n_checks++;
      if (v !== exp_v[i]) begin n_fail++; $display("FAIL mixed_step%0d: got %b exp %b", i, v, exp_v[i]); end
      n_checks++;
      if ((t - tp) !== ((i == 0) ? 1 : 4)) begin n_fail++; $display("FAIL mixed_gap%0d: got %0d exp %0d", i, t - tp, (i == 0) ? 1 : 4); end
      tp = t;
      // Retarget while the gap after the second step is running.
      if (i == 1) apb_write(A_CTRL, 32'h3);
    end
    repeat (10) begin @(posedge pclk); #1; end
    n_checks++;
    if (sys_rst_n !== 4'b0011) begin n_fail++; $display("FAIL mixed_final: got %b exp 0011", sys_rst_n); end
  endtask

  task automatic test_zero_delay_lock();
    logic [3:0]  v;
    logic [3:0]  exp_v [4];
    int unsigned t, tp;
    logic [31:0] rd;
    exp_v = '{4'b0001, 4'b0011, 4'b0111, 4'b1111};
    apb_write(A_DELAY, 32'd0);
    apb_write(A_CTRL, 32'h0);
    repeat (2) wait_change(10, v, t);
    apb_write(A_CTRL, 32'hF);
    tp = cycle;
    for (int i = 0; i < 4; i++) begin
      wait_change(10, v, t);
      n_checks++;
      if (v !== exp_v[i]) begin n_fail++; $display("FAIL zd_step%0d: got %b exp %b", i, v, exp_v[i]); end
      n_checks++;
      if ((t - tp) !== 1) begin n_fail++; $display("FAIL zd_gap%0d: got %0d exp 1", i, t - tp); end
      tp = t;
    end
    apb_write(A_CTRL, 32'h8000_000F);
    apb_write(A_CTRL, 32'h0);
    repeat (5) begin @(posedge pclk); #1; end
    n_checks++;
    if (sys_rst_n !== 4'b1111) begin n_fail++; $display("FAIL lock_hold: got %b exp 1111", sys_rst_n); end
    n_checks++;
    if (pmu_busy !== 1'b0) begin n_fail++; $display("FAIL lock_busy: got %b exp 0", pmu_busy); end
    apb_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h8000_000F) begin n_fail++; $display("FAIL lock_read: got %h exp 8000000f", rd); end
    apb_write(A_STATUS, 32'hFFFF_FFFF);
    apb_read(A_STATUS, rd);
    n_checks++;
    if (rd !== 32'h0000_000F) begin n_fail++; $display("FAIL status_ro: got %h exp 0000000f", rd); end
  endtask

  task automatic test_reset_mid();
    logic [3:0]  v;
    int unsigned t, tp;
    logic [31:0] rd;
    logic [3:0]  prev;
    logic [3:0]  exp_v [2];
    int          n;
    @(posedge pclk); #1;
    presetn = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    apb_write(A_CTRL, 32'hF);
    tp = cycle;
    wait_change(40, v, t);
    n_checks++;
    if (v !== 4'b0001 || (t - tp) !== 1) begin n_fail++; $display("FAIL mid_first: got %b@%0d exp 0001@1", v, t - tp); end
    tp = t;
    wait_change(40, v, t);
    n_checks++;
    if (v !== 4'b0011 || (t - tp) !== 16) begin n_fail++; $display("FAIL mid_second: got %b@%0d exp 0011@16", v, t - tp); end
    repeat (3) begin @(posedge pclk); #1; end
    #3 presetn = 1'b0;
    #1;
    n_checks++;
    if (sys_rst_n !== 4'b0000) begin n_fail++; $display("FAIL async_reset: got %b exp 0000", sys_rst_n); end
    n_checks++;
    if (pmu_busy !== 1'b0) begin n_fail++; $display("FAIL async_busy: got %b exp 0", pmu_busy); end
    @(posedge pclk); #1;
    presetn = 1'b1;
    apb_read(A_CTRL, rd);
    n_checks++;
    if (rd !== 32'h0) begin n_fail++; $display("FAIL post_reset_ctrl: got %h exp 00000000", rd); end
    apb_read(A_DELAY, rd);
    n_checks++;
    if (rd !== 32'hF) begin n_fail++; $display("FAIL post_reset_delay: got %h exp 0000000f", rd); end
    n_checks++;
    if (sys_rst_n !== 4'b0000) begin n_fail++; $display("FAIL post_reset_rst_n: got %b exp 0000", sys_rst_n); end

    // Second instance: nonzero RST_INIT self-releases at the default gap.
    exp_v = '{4'b0001, 4'b0101};
    @(posedge pclk); #1;
    presetn2 = 1'b1;
    tp = cycle;
    for (int i = 0; i < 2; i++) begin
      prev = sys_rst_n2;
      n = 0;
      do begin @(posedge pclk); #1; n++; end while (sys_rst_n2 === prev && n < 40);
      t = cycle;
      n_checks++;
      if (sys_rst_n2 !== exp_v[i]) begin n_fail++; $display("FAIL init_step%0d: got %b exp %b", i, sys_rst_n2, exp_v[i]); end
      n_checks++;
      if ((t - tp) !== ((i == 0) ? 1 : 16)) begin n_fail++; $display("FAIL init_gap%0d: got %0d exp %0d", i, t - tp, (i == 0) ? 1 : 16); end
      tp = t;
    end
    repeat (20) begin @(posedge pclk); #1; end
    n_checks++;
    if (pmu_busy2 !== 1'b0 || sys_rst_n2 !== 4'b0101) begin
      n_fail++; $display("FAIL init_settle: got busy=%b rst_n=%b exp busy=0 rst_n=0101", pmu_busy2, sys_rst_n2);
    end
  endtask

  initial begin
    presetn = 1'b0; presetn2 = 1'b0;
    psel = 1'b0; psel2 = 1'b0; pwrite = 1'b0; penable = 1'b0;
    paddr = '0; pwdata = '0;
    repeat (3) @(posedge pclk);
    #1 presetn = 1'b1;
    test_reset();
    test_release();
    test_assert_order();
    test_mixed_retarget();
    test_zero_delay_lock();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
